uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART, sitting directly downstream of the transmit path. It accepts one asynchronous line carrying the frame the transmitter produces: start bit 0, 8 data bits LSB-first, 1 parity bit, stop bit 1. It oversamples each bit, recovers the byte and checks parity and stop bit. It presents the byte with a single-cycle valid strobe and error flags to the host-side logic.

## Interface
Parameters:
- OVERSAMPLE, 16: clocks per bit period; even, ≥4.
- PARITY_ODD, 0: 0 = even parity expected (data ^ parity = 0); 1 = odd parity expected.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- rx  in  1  asynchronous serial line, idles high.
- rx_data  out  8  last received byte; held until next rx_valid.
- rx_valid  out  1  one-cycle strobe: rx_data/parity_err/frame_err updated.
- parity_err  out  1  parity mismatch on the frame flagged by rx_valid.
- frame_err  out  1  stop bit sampled 0 on the frame flagged by rx_valid.
- rx_busy  out  1  high in every state except IDLE.

## Operation
- rx passes through a 2-flop synchronizer, reset value 1; rx_s is the synchronizer output. All decisions use rx_s.
- Bit counter cnt (width clog2(OVERSAMPLE)) clears to 0 on every state entry and increments every cycle within a state.
- Bit index idx (3 bits) counts data bits; shift register sr (8 bits) shifts right, so each new bit enters at sr[7].
- States:
  - IDLE: leave for START when rx_s==0.
  - START: at cnt==OVERSAMPLE/2-1, sample rx_s. 0 -> DATA with idx=0. 1 -> glitch: back to IDLE, no strobe, no flags.
  - DATA: at cnt==OVERSAMPLE-1, shift rx_s into sr and increment idx. After the 8th bit (idx was 7) -> PARITY.
  - PARITY: at cnt==OVERSAMPLE-1, latch perr = (^sr ^ rx_s ^ PARITY_ODD) -> STOP.
  - STOP: at cnt==OVERSAMPLE-1, sample rx_s. 1 -> IDLE. 0 -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE; no new start detection until then.
- On the STOP sample cycle, register the outputs: rx_data<=sr, parity_err<=perr, frame_err<=~rx_s, rx_valid<=1. rx_valid is 1 for exactly one cycle.
- Flags are valid only with rx_valid and hold their values until the next strobe.
- A frame with errors still updates rx_data.
- No receive buffer: the consumer must take rx_data before the next strobe. The next strobe occurs no sooner than 10·OVERSAMPLE+OVERSAMPLE/2 cycles later.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE, synchronizer=1.
- Reset mid-frame aborts the frame: no strobe, outputs as above on the next cycle.
- Let t0 be the first cycle with rx_s==0 in IDLE. rx_s lags the pin fall by 2 cycles. Let H=OVERSAMPLE/2, N=OVERSAMPLE.
  - START sample: t0+H.
  - Data bit k sample: t0+H+(k+1)·N.
  - Parity sample: t0+H+9N.
  - Stop sample: t0+H+10N.
  - rx_valid high on cycle t0+H+10N+1.
- N=16: rx_valid at t0+169, i.e. 171 cycles after the pin's falling edge.
- rx_busy rises at t0+1. It falls on the cycle after the stop sample when stop==1. When stop==0 it falls one cycle after rx_s returns to 1 in BREAK.
- Back-to-back frames: a start edge visible in the cycle immediately after returning to IDLE is accepted.
- There is no gap requirement beyond one stop bit.

## Test plan
- Nominal, N=16: 0xA5 with even parity bit 0, stop 1 -> exactly one rx_valid pulse, 171 cycles after the pin fall. Expect rx_data=0xA5, parity_err=0, frame_err=0.
- Parity error: 0x01 sent with parity bit 0 -> rx_data=0x01, parity_err=1, frame_err=0.
- PARITY_ODD=1 instance: 0x01 with parity 0 -> parity_err=0.
- Framing/break: 0x3C with stop bit 0, then line held low 40 bit times -> one strobe with frame_err=1, rx_busy high throughout the low period, no second frame. After the line returns high, 0x55 is received cleanly.
- Glitch rejection: rx low for 4 cycles, then high -> no rx_valid, rx_busy returns 0 by t0+H+1. A subsequent 0xFF frame is received with no errors.
- Reset mid-frame: reset for 1 cycle during data bit 3 of 0x0F -> no strobe, all outputs at reset values. A following 0xC3 frame decodes correctly.
- Back-to-back: 0x00, 0xFF, 0x81 sent with single stop bits and no idle gap -> three strobes, correct bytes, no errors.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8-data-bit, 1-parity-bit, 1-stop-bit frames.
// Ports: clk, reset (sync, active-high), rx (async line, idles high),
//   rx_data/rx_valid/parity_err/frame_err to the host, rx_busy when not idle.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_next;

    logic [1:0]    sync;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;
    logic          perr;
    logic          bit_tick;
    logic          mid_tick;

    assign rx_s     = sync[1];
    assign bit_tick = (cnt == FULL_M1);
    assign mid_tick = (cnt == HALF_M1);

    // Two-flop synchronizer; resets to the idle level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                // High at mid start bit is a glitch, not a frame
                if (mid_tick) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_tick && idx == 3'd7) state_next = S_PARITY;
            end
            S_PARITY: begin
                if (bit_tick) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_tick) state_next = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                // Hold off new start detection until the line is released
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Restart on entry and at each bit boundary so a non-power-of-2
            // oversample rate still spaces data bits evenly
            if (state_next != state || bit_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == S_START) begin
                idx <= '0;
            end
            if (state == S_DATA && bit_tick) begin
                sr  <= {rx_s, sr[7:1]};
                idx <= idx + 3'd1;
            end
            if (state == S_PARITY && bit_tick) begin
                perr <= (^sr) ^ rx_s ^ PARITY_ODD;
            end
            if (state == S_STOP && bit_tick) begin
                rx_data    <= sr;
                parity_err <= perr;
                frame_err  <= ~rx_s;
                rx_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (even and odd parity instances).
// Frames are driven on the pin; strobes are logged by a negedge monitor.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int LAT = 10 * N + N / 2 + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data, o_data;
    logic       rx_valid, o_valid;
    logic       parity_err, o_perr;
    logic       frame_err, o_ferr;
    logic       rx_busy, o_busy;

    uart_rx #(.OVERSAMPLE(N), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    uart_rx #(.OVERSAMPLE(N), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .rx(rx),
        .rx_data(o_data), .rx_valid(o_valid),
        .parity_err(o_perr), .frame_err(o_ferr),
        .rx_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Strobe log: {perr, ferr, data} per strobe
    logic [9:0] logq[$];
    int         last_cyc = 0;
    int         ocount = 0;
    logic       o_last_perr = 1'b0;
    int         fall_cyc = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            logq.push_back({parity_err, frame_err, rx_data});
            last_cyc = cyc;
        end
        if (o_valid) begin
            ocount++;
            o_last_perr = o_perr;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic chk_last(input string name, input logic [7:0] d,
                            input logic pe, input logic fe);
        logic [9:0] e;
        e = (logq.size() > 0) ? logq[logq.size()-1] : 10'h3ff;
        chk({name, " data"}, int'(e[7:0]), int'(d));
        chk({name, " perr"}, int'(e[9]), int'(pe));
        chk({name, " ferr"}, int'(e[8]), int'(fe));
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       par;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_ope;
    } vec_t;

    vec_t vt[5];

    initial begin
        int   base;
        int   obase;
        logic busy_all;
        logic [9:0] e;

        vt[0] = '{d: 8'hA5, par: 1'b0, exp_d: 8'hA5, exp_pe: 1'b0, exp_ope: 1'b1};
        vt[1] = '{d: 8'h01, par: 1'b0, exp_d: 8'h01, exp_pe: 1'b1, exp_ope: 1'b0};
        vt[2] = '{d: 8'h80, par: 1'b1, exp_d: 8'h80, exp_pe: 1'b0, exp_ope: 1'b1};
        vt[3] = '{d: 8'h07, par: 1'b0, exp_d: 8'h07, exp_pe: 1'b1, exp_ope: 1'b0};
        vt[4] = '{d: 8'h3C, par: 1'b1, exp_d: 8'h3C, exp_pe: 1'b1, exp_ope: 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset parity_err", int'(parity_err), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset rx_busy", int'(rx_busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        // Table-driven nominal frames
        for (int i = 0; i < 5; i++) begin
            base  = logq.size();
            obase = ocount;
            send_frame(vt[i].d, vt[i].par, 1'b1);
            idle(4);
            chk($sformatf("vec%0d strobes", i), logq.size() - base, 1);
            chk($sformatf("vec%0d latency", i), last_cyc - fall_cyc, LAT);
            chk_last($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_pe, 1'b0);
            chk($sformatf("vec%0d odd strobes", i), ocount - obase, 1);
            chk($sformatf("vec%0d odd perr", i), int'(o_last_perr),
                int'(vt[i].exp_ope));
            chk($sformatf("vec%0d busy after", i), int'(rx_busy), 0);
        end

        // Framing error followed by a long break
        base = logq.size();
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        busy_all = 1'b1;
        for (int b = 0; b < 40; b++) begin
            repeat (N) @(posedge clk);
            @(negedge clk);
            busy_all = busy_all & rx_busy;
        end
        chk("break strobes", logq.size() - base, 1);
        chk_last("break", 8'h3C, 1'b0, 1'b1);
        chk("break busy held", int'(busy_all), 1);
        idle(4);
        chk("break busy released", int'(rx_busy), 0);
        base = logq.size();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(4);
        chk("after break strobes", logq.size() - base, 1);
        chk_last("after break", 8'h55, 1'b0, 1'b0);

        // Glitch rejection: 4 low cycles on the pin
        base = logq.size();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        @(negedge clk);
        chk("glitch busy rise", int'(rx_busy), 1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("glitch busy fall", int'(rx_busy), 0);
        idle(2 * N);
        chk("glitch strobes", logq.size() - base, 0);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(4);
        chk("after glitch strobes", logq.size() - base, 1);
        chk_last("after glitch", 8'hFF, 1'b0, 1'b0);

        // Reset during data bit 3 of 0x0F
        base = logq.size();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (N / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset rx_data", int'(rx_data), 0);
        chk("midreset rx_valid", int'(rx_valid), 0);
        chk("midreset parity_err", int'(parity_err), 0);
        chk("midreset frame_err", int'(frame_err), 0);
        chk("midreset rx_busy", int'(rx_busy), 0);
        idle(12 * N);
        chk("midreset strobes", logq.size() - base, 0);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(4);
        chk("after reset strobes", logq.size() - base, 1);
        chk_last("after reset", 8'hC3, 1'b0, 1'b0);

        // Back-to-back frames with no idle gap
        base = logq.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        chk("b2b strobes", logq.size() - base, 3);
        for (int j = 0; j < 3; j++) begin
            e = (logq.size() > base + j) ? logq[base+j] : 10'h3ff;
            chk($sformatf("b2b%0d data", j), int'(e[7:0]),
                (j == 0) ? 'h00 : (j == 1) ? 'hFF : 'h81);
            chk($sformatf("b2b%0d flags", j), int'(e[9:8]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
